// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter sharing one single-port data memory.
// Port 0 wins the first tie after reset; read data returns one cycle after the grant edge.
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] LP_DEPTH = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    port_e                 r_last_grant;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  r_err0;
    logic                  r_err1;

    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_in_range0;
    logic                  w_in_range1;

    assign w_in_range0 = (req0_addr < LP_DEPTH);
    assign w_in_range1 = (req1_addr < LP_DEPTH);

    // On a tie the port that did not win last time is granted.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant0 = (r_last_grant == PORT1);
            w_grant1 = (r_last_grant == PORT0);
        end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (w_grant0) begin
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
            mem_we    = req0_we && w_in_range0;
        end else if (w_grant1) begin
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
            mem_we    = req1_we && w_in_range1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= PORT1;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
        end else begin
            r_rvalid0 <= w_grant0 && !req0_we;
            r_rvalid1 <= w_grant1 && !req1_we;
            if (w_grant0) begin
                r_last_grant <= PORT0;
            end else if (w_grant1) begin
                r_last_grant <= PORT1;
            end
            // Out-of-range reads still complete, returning zero.
            if (w_grant0 && !req0_we) begin
                r_rdata0 <= w_in_range0 ? mem_rdata : '0;
            end
            if (w_grant1 && !req1_we) begin
                r_rdata1 <= w_in_range1 ? mem_rdata : '0;
            end
            if (w_grant0 && !w_in_range0) begin
                r_err0 <= 1'b1;
            end
            if (w_grant1 && !w_in_range1) begin
                r_err1 <= 1'b1;
            end
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign req0_rvalid = r_rvalid0;
    assign req1_rvalid = r_rvalid1;
    assign req0_rdata  = r_rdata0;
    assign req1_rdata  = r_rdata1;
    assign req0_err    = r_err0;
    assign req1_err    = r_err1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios then randomized traffic,
// each cycle compared against a behavioural model of arbitration and memory.
module tb_data_mem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          req0_valid = 1'b0, req0_we = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req0_ready, req0_rvalid, req0_err;
    logic [DW-1:0] req0_rdata;

    logic          req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req1_ready, req1_rvalid, req1_err;
    logic [DW-1:0] req1_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] tb_mem  [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int            m_last;
    bit            m_rv  [2];
    logic [DW-1:0] m_rd  [2];
    bit            m_err [2];

    int            n_pass  = 0;
    int            n_total = 0;

    data_mem_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req0_rvalid(req0_rvalid),
        .req0_rdata (req0_rdata),
        .req0_err   (req0_err),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .req1_rvalid(req1_rvalid),
        .req1_rdata (req1_rdata),
        .req1_err   (req1_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT: combinational read, write on the clock edge.
    always @(posedge clk) begin
        if (mem_we && mem_addr < AW'(DEPTH)) tb_mem[mem_addr[6:0]] <= mem_wdata;
    end
    assign mem_rdata = (mem_addr < AW'(DEPTH)) ? tb_mem[mem_addr[6:0]] : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_last = 1;
        for (int i = 0; i < 2; i++) begin
            m_rv[i]  = 1'b0;
            m_rd[i]  = '0;
            m_err[i] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One cycle: inputs already driven; check at negedge, advance model at posedge.
    task automatic step(output int granted);
        int            g;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        logic          gwe;
        bit            ok;
        g = -1;
        if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
        ga  = (g == 0) ? req0_addr  : (g == 1) ? req1_addr  : '0;
        gd  = (g == 0) ? req0_wdata : (g == 1) ? req1_wdata : '0;
        gwe = (g == 0) ? req0_we    : (g == 1) ? req1_we    : 1'b0;
        ok  = (ga < AW'(DEPTH));

        @(negedge clk);
        chk("ready0",    64'(req0_ready),  64'(g == 0));
        chk("ready1",    64'(req1_ready),  64'(g == 1));
        chk("mem_we",    64'(mem_we),      64'(g >= 0 && gwe && ok));
        chk("mem_addr",  64'(mem_addr),    64'(ga));
        chk("mem_wdata", 64'(mem_wdata),   64'(gd));
        chk("rvalid0",   64'(req0_rvalid), 64'(m_rv[0]));
        chk("rvalid1",   64'(req1_rvalid), 64'(m_rv[1]));
        chk("rdata0",    64'(req0_rdata),  64'(m_rd[0]));
        chk("rdata1",    64'(req1_rdata),  64'(m_rd[1]));
        chk("err0",      64'(req0_err),    64'(m_err[0]));
        chk("err1",      64'(req1_err),    64'(m_err[1]));

        @(posedge clk);
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (g >= 0) begin
            m_last = g;
            if (!ok) m_err[g] = 1'b1;
            if (gwe) begin
                if (ok) ref_mem[ga[6:0]] = gd;
            end else begin
                m_rv[g] = 1'b1;
                m_rd[g] = ok ? ref_mem[ga[6:0]] : '0;
            end
        end
        #1;
        granted = g;
    endtask

    initial begin
        int g;
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        tb_mem[0] = 32'd4;  ref_mem[0] = 32'd4;
        tb_mem[5] = 32'd24; ref_mem[5] = 32'd24;

        do_reset();

        // Single read on port 0, then observe the response.
        req0_valid = 1'b1; req0_addr = 32'd5;
        step(g);
        chk("first_grant", 64'(g), 64'(0));
        idle_inputs();
        step(g);
        chk("rdata0_is_24", 64'(req0_rdata), 64'd24);

        // Continuous contention from reset: 0,1,0,1,0,1.
        do_reset();
        req0_valid = 1'b1; req0_addr = 32'd0;
        req1_valid = 1'b1; req1_addr = 32'd5;
        for (int c = 0; c < 6; c++) begin
            step(g);
            chk("alternate", 64'(g), 64'(c % 2));
        end
        idle_inputs();
        step(g);

        // Write on port 1 followed by a read of the same word on port 0.
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'd3; req1_wdata = 32'hDEAD_BEEF;
        step(g);
        idle_inputs();
        req0_valid = 1'b1; req0_addr = 32'd3;
        step(g);
        idle_inputs();
        step(g);
        chk("raw_rdata0", 64'(req0_rdata), 64'h0000_0000_DEAD_BEEF);

        // Out-of-range write then read.
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'd200; req0_wdata = 32'h1234_5678;
        step(g);
        idle_inputs();
        req0_valid = 1'b1; req0_addr = 32'd200;
        step(g);
        idle_inputs();
        step(g);
        chk("mem72_untouched", 64'(tb_mem[72]), 64'd0);
        chk("oor_rdata0", 64'(req0_rdata), 64'd0);

        // Asynchronous reset with a read response pending.
        req0_valid = 1'b1; req0_addr = 32'd5;
        step(g);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid0", 64'(req0_rvalid), 64'd0);
        chk("arst_rdata0",  64'(req0_rdata),  64'd0);
        chk("arst_err0",    64'(req0_err),    64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_addr = 32'd0;
        req1_valid = 1'b1; req1_addr = 32'd5;
        step(g);
        chk("tie_after_reset", 64'(g), 64'(0));

        // Idle cycles preserve the round-robin pointer.
        idle_inputs();
        for (int c = 0; c < 5; c++) step(g);
        req0_valid = 1'b1; req0_addr = 32'd0;
        req1_valid = 1'b1; req1_addr = 32'd5;
        step(g);
        chk("tie_after_idle", 64'(g), 64'(1));
        idle_inputs();
        step(g);

        // Randomized traffic; requests stay stable until granted.
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid && $urandom_range(0, 3) != 0) begin
                req0_valid = 1'b1;
                req0_we    = 1'($urandom_range(0, 1));
                req0_addr  = $urandom_range(0, 139);
                req0_wdata = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 3) != 0) begin
                req1_valid = 1'b1;
                req1_we    = 1'($urandom_range(0, 1));
                req1_addr  = (c % 5 == 0) ? req0_addr : 32'($urandom_range(0, 139));
                req1_wdata = $urandom;
            end
            step(g);
            if (g == 0) req0_valid = 1'b0;
            if (g == 1) req1_valid = 1'b0;
        end
        idle_inputs();
        step(g);
        for (int i = 0; i < DEPTH; i++) chk("mem_final", 64'(tb_mem[i]), 64'(ref_mem[i]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
